// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Shares the core's single memory port between the instruction fetch unit
// (master 0) and the load/store unit (master 1). Grants round-robin, registers
// the winning request, and holds the grant until that request's response has
// been returned, so at most one transaction is ever outstanding.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   m0_req_valid/ready/req         IFU request handshake + payload
//   m0_resp_valid/ready/resp       IFU response handshake + payload
//   m1_*                           same set for the LSU
//   s_req_valid/ready/req          request to the memory/bus bridge
//   s_resp_valid/ready/resp        response from the memory/bus bridge
// Request payload  : {addr, wen, wdata, wmask}, addr in the MSBs
// Response payload : {rdata, err}
// -----------------------------------------------------------------------------
module bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int REQ_W  = ADDR_W + 1 + DATA_W + DATA_W / 8,
    parameter int RESP_W = DATA_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [REQ_W-1:0]  m0_req,
    output logic              m0_resp_valid,
    input  logic              m0_resp_ready,
    output logic [RESP_W-1:0] m0_resp,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [REQ_W-1:0]  m1_req,
    output logic              m1_resp_valid,
    input  logic              m1_resp_ready,
    output logic [RESP_W-1:0] m1_resp,
    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [REQ_W-1:0]  s_req,
    input  logic              s_resp_valid,
    output logic              s_resp_ready,
    input  logic [RESP_W-1:0] s_resp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic               last_grant_r;
    logic               grant_r;
    logic [REQ_W-1:0]   req_r;

    logic               any_valid_s;
    logic               win_s;

    // On a tie the master that was not served last wins; otherwise the only
    // requester wins. win_s is only meaningful while any_valid_s is set.
    assign any_valid_s = m0_req_valid | m1_req_valid;
    assign win_s       = (m0_req_valid & m1_req_valid) ? ~last_grant_r : m1_req_valid;

    // The registered request is presented directly; it stays stable until the
    // next grant, which can only happen after the response completes.
    assign s_req = req_r;

    // Responses are broadcast to both masters; only the resp_valid bits qualify.
    assign m0_resp = s_resp;
    assign m1_resp = s_resp;

    // Handshake strobes decoded from the current state (zero-cycle request ready).
    always_comb begin
        m0_req_ready  = 1'b0;
        m1_req_ready  = 1'b0;
        m0_resp_valid = 1'b0;
        m1_resp_valid = 1'b0;
        s_req_valid   = 1'b0;
        s_resp_ready  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (any_valid_s) begin
                    if (win_s) begin
                        m1_req_ready = 1'b1;
                    end else begin
                        m0_req_ready = 1'b1;
                    end
                end else begin
                    m0_req_ready = 1'b0;
                end
            end
            ST_REQ: begin
                s_req_valid = 1'b1;
            end
            ST_RESP: begin
                if (grant_r) begin
                    s_resp_ready  = m1_resp_ready;
                    m1_resp_valid = s_resp_valid;
                end else begin
                    s_resp_ready  = m0_resp_ready;
                    m0_resp_valid = s_resp_valid;
                end
            end
            default: begin
                s_req_valid = 1'b0;
            end
        endcase
    end

    // Transaction FSM: capture the winner, hand it to the slave, return the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            grant_r      <= 1'b0;
            req_r        <= {REQ_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_valid_s) begin
                        grant_r <= win_s;
                        req_r   <= win_s ? m1_req : m0_req;
                        state_r <= ST_REQ;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (s_req_ready) begin
                        state_r <= ST_RESP;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_RESP: begin
                    // Round-robin history advances only when a transaction completes.
                    if (s_resp_valid && s_resp_ready) begin
                        last_grant_r <= grant_r;
                        state_r      <= ST_IDLE;
                    end else begin
                        state_r <= ST_RESP;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed scenarios followed by a randomized run. A transaction-level model
// (is a transaction open, has it reached the slave, who owns it, who was
// served last) predicts every handshake output on every cycle.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int MW  = DW / 8;
    localparam int RQW = AW + 1 + DW + MW;
    localparam int RSW = DW + 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]     mv;
    logic [RQW-1:0] mreq [2];
    logic [1:0]     mrr;
    logic [1:0]     mrdy;
    logic [1:0]     mrv;
    logic [RSW-1:0] mresp0, mresp1;
    logic           s_req_valid, s_req_ready, s_resp_valid, s_resp_ready;
    logic [RQW-1:0] s_req;
    logic [RSW-1:0] s_resp;

    bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(mv[0]), .m0_req_ready(mrdy[0]), .m0_req(mreq[0]),
        .m0_resp_valid(mrv[0]), .m0_resp_ready(mrr[0]), .m0_resp(mresp0),
        .m1_req_valid(mv[1]), .m1_req_ready(mrdy[1]), .m1_req(mreq[1]),
        .m1_resp_valid(mrv[1]), .m1_resp_ready(mrr[1]), .m1_resp(mresp1),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req(s_req),
        .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready), .s_resp(s_resp)
    );

    int checks = 0;
    int failures = 0;

    // transaction-level model
    bit             busy, sent, owner, last_served;
    logic [RQW-1:0] pay;
    bit [1:0]       exp_rdy;
    bit             any_req, pick;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [RQW-1:0] rnd_req();
        return {$urandom, 1'($urandom), $urandom, 4'($urandom)};
    endfunction

    task automatic model_check();
        bit       e_srv, e_srr;
        bit [1:0] e_rv;
        any_req = mv[0] | mv[1];
        pick    = (mv[0] && mv[1]) ? !last_served : mv[1];
        exp_rdy = 2'b00; e_srv = 1'b0; e_srr = 1'b0; e_rv = 2'b00;
        if (!busy) begin
            if (any_req) exp_rdy[pick] = 1'b1;
        end else if (!sent) begin
            e_srv = 1'b1;
        end else begin
            e_srr       = mrr[owner];
            e_rv[owner] = s_resp_valid;
        end
        chk("m_req_ready", mrdy, exp_rdy);
        chk("m_resp_valid", mrv, e_rv);
        chk("s_req_valid", s_req_valid, e_srv);
        chk("s_resp_ready", s_resp_ready, e_srr);
        chk("s_req", s_req, pay);
        chk("m0_resp", mresp0, s_resp);
        chk("m1_resp", mresp1, s_resp);
    endtask

    task automatic model_update();
        if (rst) begin
            busy = 1'b0; sent = 1'b0; owner = 1'b0; last_served = 1'b1; pay = '0;
        end else if (!busy) begin
            if (any_req) begin
                busy = 1'b1; sent = 1'b0; owner = pick; pay = mreq[pick];
            end
        end else if (!sent) begin
            if (s_req_ready) sent = 1'b1;
        end else if (s_resp_valid && mrr[owner]) begin
            busy = 1'b0; last_served = owner;
        end
    endtask

    task automatic step();
        #1;
        model_check();
    endtask

    task automatic tick();
        model_update();
        @(negedge clk);
    endtask

    task automatic drain();
        bit       done = 1'b0;
        bit [1:0] nxt;
        s_req_ready = 1'b1; s_resp_valid = 1'b1; mrr = 2'b11;
        for (int i = 0; i < 30 && !done; i++) begin
            step();
            nxt = mv & ~exp_rdy;
            tick();
            mv = nxt;
            if (!busy && mv == 2'b00) done = 1'b1;
        end
        chk("drain_timeout", done, 1'b1);
        s_resp_valid = 1'b0; mrr = 2'b00;
    endtask

    initial begin
        int       order [$];
        logic [RQW-1:0] held;
        bit [1:0] nxt;

        rst = 1'b1; mv = 2'b00; mrr = 2'b00; mreq[0] = '0; mreq[1] = '0;
        s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp = '0;
        busy = 1'b0; sent = 1'b0; owner = 1'b0; last_served = 1'b1; pay = '0;
        @(negedge clk); @(negedge clk);
        model_update();
        rst = 1'b0;

        // reset state
        step();
        chk("reset_s_req_valid", s_req_valid, 1'b0);
        chk("reset_s_req", s_req, {RQW{1'b0}});
        chk("reset_ready", mrdy, 2'b00);
        tick();

        // single IFU read
        mv = 2'b01; mreq[0] = {32'h8000_0000, 1'b0, 32'h0, 4'h0}; s_req_ready = 1'b1; mrr = 2'b01;
        step(); chk("t1_m0_ready", mrdy, 2'b01); tick();
        mv = 2'b00;
        step(); chk("t1_s_req_valid", s_req_valid, 1'b1); chk("t1_addr", s_req[RQW-1 -: AW], 32'h8000_0000); tick();
        s_resp_valid = 1'b1; s_resp = {32'h0000_0413, 1'b0};
        step(); chk("t1_m0_resp_valid", mrv, 2'b01); chk("t1_rdata", mresp0[RSW-1:1], 32'h0000_0413); tick();
        s_resp_valid = 1'b0;
        step(); tick();

        // simultaneous first request after reset
        rst = 1'b1; step(); tick(); rst = 1'b0;
        mv = 2'b11; mreq[0] = rnd_req(); mreq[1] = rnd_req(); mrr = 2'b11;
        step(); chk("t2_first_grant", mrdy, 2'b01); tick();
        mv = 2'b10;
        step(); chk("t2_m1_wait_req", mrdy[1], 1'b0); tick();
        s_resp_valid = 1'b1;
        step(); chk("t2_m1_wait_resp", mrdy[1], 1'b0); tick();
        s_resp_valid = 1'b0;
        step(); chk("t2_m1_granted", mrdy, 2'b10); tick();
        mv = 2'b00;
        drain();

        // continuous contention: 4 transactions in 12 cycles
        mv = 2'b11; mreq[0] = rnd_req(); mreq[1] = rnd_req();
        s_req_ready = 1'b1; s_resp_valid = 1'b1; mrr = 2'b11;
        for (int c = 0; c < 12; c++) begin
            step();
            if (mrdy[0]) order.push_back(0);
            if (mrdy[1]) order.push_back(1);
            nxt = mrdy;
            tick();
            if (nxt[0]) mreq[0] = rnd_req();
            if (nxt[1]) mreq[1] = rnd_req();
        end
        chk("t3_count", order.size(), 4);
        if (order.size() == 4) begin
            chk("t3_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
        end

        // slave request backpressure (m0 wins, m1 keeps waiting)
        s_resp_valid = 1'b0; s_req_ready = 1'b1;
        step(); chk("t4_grant", mrdy, 2'b01); held = mreq[0]; tick();
        mv = 2'b10; s_req_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) s_req_ready = 1'b1;
            step();
            chk("t4_s_req_valid", s_req_valid, 1'b1);
            chk("t4_s_req_hold", s_req, held);
            chk("t4_m1_blocked", mrdy[1], 1'b0);
            tick();
        end
        drain();

        // master response backpressure on an LSU write
        mv = 2'b10; mreq[1] = {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}; mrr = 2'b00; s_req_ready = 1'b1;
        step(); chk("t5_grant", mrdy, 2'b10); tick();
        mv = 2'b00;
        step(); chk("t5_s_req", s_req, {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'hF}); tick();
        s_resp_valid = 1'b1; s_resp = {$urandom, 1'b0};
        for (int c = 0; c < 3; c++) begin
            step(); chk("t5_s_resp_ready", s_resp_ready, 1'b0); chk("t5_m1_resp_valid", mrv, 2'b10); tick();
        end
        mrr = 2'b10;
        step(); chk("t5_complete", s_resp_ready, 1'b1); tick();
        s_resp_valid = 1'b0; mrr = 2'b00;
        step(); chk("t5_idle", s_req_valid, 1'b0); tick();

        // reset while in REQ
        mv = 2'b01; mreq[0] = rnd_req(); s_req_ready = 1'b0;
        step(); tick();
        mv = 2'b00;
        step(); chk("t6_in_req", s_req_valid, 1'b1);
        rst = 1'b1; tick(); rst = 1'b0;
        step(); chk("t6_after_rst_valid", s_req_valid, 1'b0); chk("t6_after_rst_req", s_req, {RQW{1'b0}}); tick();
        mv = 2'b11; mreq[0] = rnd_req(); mreq[1] = rnd_req();
        step(); chk("t6_tie_m0", mrdy, 2'b01); tick();
        mv = 2'b10;
        drain();

        // randomized traffic with protocol-respecting masters
        for (int c = 0; c < 3000; c++) begin
            s_req_ready  = ($urandom_range(0, 3) != 0);
            s_resp_valid = $urandom_range(0, 1);
            s_resp       = {$urandom, 1'($urandom)};
            mrr          = 2'($urandom);
            rst          = ($urandom_range(0, 199) == 0);
            step();
            for (int i = 0; i < 2; i++) begin
                if (mv[i] && exp_rdy[i]) begin
                    nxt[i] = ($urandom_range(0, 1) == 1);
                end else if (!mv[i]) begin
                    nxt[i] = ($urandom_range(0, 9) < 4);
                end else begin
                    nxt[i] = 1'b1;
                end
            end
            if (rst) nxt = 2'b00;
            held = mreq[0];
            tick();
            for (int i = 0; i < 2; i++) begin
                if (nxt[i] && (!mv[i] || exp_rdy[i])) mreq[i] = rnd_req();
            end
            mv = nxt;
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave request/response arbiter that shares the core's single memory port between the instruction fetch unit (master 0) and the load/store unit (master 1). Each side uses the same valid/ready handshake as the pipeline stage registers. The arbiter sits between the IFU/LSU and the memory/bus bridge. It grants round-robin, registers the winning request, and holds the grant until that request's response has been handed back, so at most one transaction is outstanding.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; write mask is DATA_W/8 bits
- REQ_W, ADDR_W+1+DATA_W+DATA_W/8, packed request payload {addr, wen, wdata, wmask} (addr in MSBs)
- RESP_W, DATA_W+1, packed response payload {rdata, err}
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- m0_req_valid  in  1  IFU request valid
- m0_req_ready  out  1  IFU request accepted this cycle
- m0_req  in  REQ_W  IFU request payload
- m0_resp_valid  out  1  response valid to IFU
- m0_resp_ready  in  1  IFU accepts response
- m0_resp  out  RESP_W  response payload to IFU
- m1_req_valid / m1_req_ready / m1_req / m1_resp_valid / m1_resp_ready / m1_resp: same directions, widths and meanings for the LSU
- s_req_valid  out  1  request valid to slave
- s_req_ready  in  1  slave accepts request
- s_req  out  REQ_W  registered request payload
- s_resp_valid  in  1  slave response valid
- s_resp_ready  out  1  arbiter accepts response
- s_resp  in  RESP_W  slave response payload

## Operation
- States:
  - IDLE: arbitrate.
  - REQ: present the request to the slave.
  - RESP: wait for the response and return it to the granted master.
- IDLE:
  - If any mX_req_valid is set, pick a winner.
  - If only one master is valid, it wins.
  - If both are valid, the master not equal to last_grant wins.
  - Assert the winner's mX_req_ready combinationally in the same cycle; the loser's ready stays 0.
  - Capture the winner's payload into req_q and the winner index into grant_q, then go to REQ.
- REQ:
  - s_req_valid=1 and s_req=req_q, held stable until s_req_ready.
  - On the s_req_valid & s_req_ready handshake, go to RESP.
- RESP:
  - s_resp_ready = m[grant_q]_resp_ready.
  - m[grant_q]_resp_valid = s_resp_valid and m[grant_q]_resp = s_resp.
  - The other master sees resp_valid=0.
  - On the s_resp_valid & s_resp_ready handshake: last_grant <= grant_q, go to IDLE.
- No other state drives any mX_req_ready, mX_resp_valid, s_req_valid or s_resp_ready. They are 0 in every state except as listed above.
- Requests that are not granted stay pending. The master must hold valid and payload stable until it sees ready.
- s_resp arriving outside RESP is never accepted, because s_resp_ready=0.
- mX_resp carries s_resp even when its valid is 0, so it may toggle. Only the valid bit is meaningful.

## Timing
- Reset values:
  - state=IDLE, last_grant=1, so m0 wins the first tie.
  - grant_q=0, req_q=0.
  - All ready/valid outputs 0, s_req=0.
- Request acceptance: mX_req_ready is asserted in the IDLE cycle where the valid is seen (zero-cycle ready). s_req_valid rises the next cycle.
- Minimum turnaround, with slave ready and response immediate: IDLE(accept) -> REQ(s_req handshake) -> RESP(resp handshake) -> IDLE. That is 3 cycles per transaction, and a new grant is possible in the cycle after the response handshake.
- Back-to-back contention: with both masters valid continuously, grants alternate m0, m1, m0, …
- last_grant updates only on response completion, never on request acceptance.
- Reset mid-transaction: all state is discarded and outputs return to reset values the next cycle. The slave and masters are reset by the same rst, so no orphan response is expected.
- wen is passed through opaquely; reads and writes follow identical sequencing, and a write still waits for its response.

## Test plan
- Single IFU read: m0_req={addr 0x8000_0000, wen 0} at cycle 0 with slave always ready, s_resp={0x0000_0413, 0} in cycle 2 -> m0_req_ready=1 at cycle 0, s_req_valid=1 at cycle 1 with addr 0x8000_0000, m0_resp_valid=1 with rdata 0x0000_0413 at cycle 2, m1 sees nothing.
- Simultaneous first request: both valid at cycle 0 after reset -> m0 granted first, m1_req_ready=0. m1 is granted in the IDLE cycle after m0's response handshake.
- Continuous contention for 4 transactions -> grant order m0, m1, m0, m1, each transaction 3 cycles.
- Slave backpressure: s_req_ready=0 for 5 cycles -> s_req_valid held 1 with unchanged payload for 6 cycles, no second grant, and m1_req_ready stays 0 throughout.
- Master response backpressure: LSU write {addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0xF} with m1_resp_ready=0 for 3 cycles after s_resp_valid -> s_resp_ready=0 for those cycles, m1_resp_valid held 1, and completion happens on the cycle m1_resp_ready=1.
- Reset in REQ state -> next cycle state is IDLE, s_req_valid=0, and a subsequent tie grants m0.
